// File: rtl/posit_mul_issue_queue.sv
// Credit-based issue stage and result FIFO around a fixed-latency, non-stallable posit multiplier.
// Operands are only issued when a FIFO slot is reserved, so every done always finds room.
module posit_mul_issue_queue #(
  parameter int N     = 32,
  parameter int DEPTH = 8,
  parameter int LAT   = 5,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [N-1:0]  op_a,
  input  logic [N-1:0]  op_b,
  output logic [N-1:0]  mul_in1,
  output logic [N-1:0]  mul_in2,
  output logic          mul_start,
  input  logic [N-1:0]  mul_out,
  input  logic          mul_inf,
  input  logic          mul_zero,
  input  logic          mul_done,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [N-1:0]  res_data,
  output logic          res_inf,
  output logic          res_zero,
  output logic [CW-1:0] inflight,
  output logic          err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW = $clog2(LAT + 2);

  localparam logic [CW:0]   DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [AW-1:0] ONE_A   = AW'(1);
  localparam logic [FW-1:0] ONE_F   = FW'(1);
  localparam logic [FW-1:0] LAT_F   = FW'(LAT);

  typedef enum logic {ST_FLUSH = 1'b0, ST_RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [FW-1:0] flush_cnt_q, flush_cnt_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          start_q, start_d;
  logic [N-1:0]  in1_q, in1_d;
  logic [N-1:0]  in2_q, in2_d;
  logic          err_q, err_d;

  logic [N+1:0]  mem [DEPTH];

  logic          run;
  logic [CW:0]   credit_used;
  logic          ready_int;
  logic          accept;
  logic          counted;
  logic          stray;
  logic          full;
  logic          push;
  logic          pop;

  // FLUSH swallows done pulses of ops launched before reset for LAT+1 cycles.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    case (state_q)
      ST_FLUSH: begin
        if (flush_cnt_q == LAT_F) begin
          state_d = ST_RUN;
        end else begin
          flush_cnt_d = flush_cnt_q + ONE_F;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_FLUSH;
    endcase
  end

  always_comb begin
    run         = (state_q == ST_RUN);
    credit_used = {1'b0, count_q} + {1'b0, inflight_q};
    ready_int   = run && (credit_used < DEPTH_W);
    accept      = op_valid && ready_int;
    counted     = mul_done && run && (inflight_q != '0);
    stray       = mul_done && run && (inflight_q == '0);
    full        = (count_q == DEPTH_C);
    push        = counted && !full;
    pop         = (count_q != '0) && res_ready;

    inflight_d = inflight_q;
    if (accept && !counted) begin
      inflight_d = inflight_q + ONE_C;
    end else if (!accept && counted) begin
      inflight_d = inflight_q - ONE_C;
    end

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + ONE_C;
    end else if (!push && pop) begin
      count_d = count_q - ONE_C;
    end

    wr_ptr_d = push ? (wr_ptr_q + ONE_A) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + ONE_A) : rd_ptr_q;

    start_d = accept;
    in1_d   = accept ? op_a : in1_q;
    in2_d   = accept ? op_b : in2_q;

    err_d = err_q || stray || (counted && full);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_FLUSH;
      flush_cnt_q <= '0;
      count_q     <= '0;
      inflight_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      start_q     <= 1'b0;
      in1_q       <= '0;
      in2_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      count_q     <= count_d;
      inflight_q  <= inflight_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      start_q     <= start_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr_q] <= {mul_inf, mul_zero, mul_out};
    end
  end

  assign op_ready  = ready_int;
  assign mul_start = start_q;
  assign mul_in1   = in1_q;
  assign mul_in2   = in2_q;
  assign res_valid = (count_q != '0);
  assign {res_inf, res_zero, res_data} = mem[rd_ptr_q];
  assign inflight  = inflight_q;
  assign err       = err_q;

endmodule

// File: tb/tb_posit_mul_issue_queue.sv
// Bench for posit_mul_issue_queue: a stand-in fixed-latency multiplier feeds the DUT and a
// transaction-level model (queue of accepted ops, credit = ops not yet popped) checks every cycle.
module tb_posit_mul_issue_queue;
  localparam int N     = 32;
  localparam int DEPTH = 8;
  localparam int LAT   = 5;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam logic [31:0] P_ONE = 32'h4000_0000;
  localparam logic [31:0] P_NAR = 32'h8000_0000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [N-1:0]  op_a = '0;
  logic [N-1:0]  op_b = '0;
  logic [N-1:0]  mul_in1, mul_in2;
  logic          mul_start;
  logic [N-1:0]  mul_out;
  logic          mul_inf, mul_zero, mul_done;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [N-1:0]  res_data;
  logic          res_inf, res_zero;
  logic [CW-1:0] inflight;
  logic          err;

  always #5 clk = ~clk;

  posit_mul_issue_queue #(.N(N), .DEPTH(DEPTH), .LAT(LAT), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_start(mul_start),
    .mul_out(mul_out), .mul_inf(mul_inf), .mul_zero(mul_zero), .mul_done(mul_done),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_inf(res_inf), .res_zero(res_zero),
    .inflight(inflight), .err(err)
  );

  // Stand-in multiplier: exact for zero, NaR and multiply-by-one; other products are an arbitrary mix.
  function automatic logic [33:0] stub_mul(input logic [31:0] a, input logic [31:0] b);
    if (a == P_NAR || b == P_NAR) return {2'b10, P_NAR};
    if (a == 32'h0 || b == 32'h0) return {2'b01, 32'h0};
    if (a == P_ONE) return {2'b00, b};
    if (b == P_ONE) return {2'b00, a};
    return {2'b00, a ^ {b[15:0], b[31:16]}};
  endfunction

  logic [LAT-1:0] pipe_v = '0;
  logic [33:0]    pipe_d [LAT];
  logic           stray_done = 1'b0;

  always @(posedge clk) begin
    pipe_v    <= {pipe_v[LAT-2:0], mul_start};
    pipe_d[0] <= stub_mul(mul_in1, mul_in2);
    for (int i = 1; i < LAT; i++) pipe_d[i] <= pipe_d[i-1];
  end

  assign mul_done = pipe_v[LAT-1] | stray_done;
  assign {mul_inf, mul_zero, mul_out} = pipe_d[LAT-1];

  int          total = 0;
  int          bad = 0;
  logic [33:0] exp_q[$];
  int          exp_inflight = 0;
  int          exp_count = 0;
  int          flush_left = 0;
  int          flush_dones = 0;
  logic        exp_err = 1'b0;
  logic        prev_acc = 1'b0;
  logic [31:0] prev_a = '0;
  logic [31:0] prev_b = '0;
  logic        last_acc, last_pop;
  logic [33:0] last_pop_val;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    logic        inf;
    logic        zero;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // One cycle: check outputs against the model, drive inputs, then account for the upcoming edge.
  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] b,
                      input logic rr, input logic sd);
    logic run, acc, pop, cnt_done;
    @(negedge clk);
    run = (flush_left == 0);
    check("op_ready", 64'(op_ready), 64'(run && (exp_q.size() < DEPTH)));
    check("inflight", 64'(inflight), 64'(exp_inflight));
    check("mul_start", 64'(mul_start), 64'(prev_acc));
    if (prev_acc) begin
      check("mul_in1", 64'(mul_in1), 64'(prev_a));
      check("mul_in2", 64'(mul_in2), 64'(prev_b));
    end
    check("err", 64'(err), 64'(exp_err));
    check("res_valid", 64'(res_valid), 64'(exp_count > 0));
    if (res_valid && exp_count > 0)
      check("res_word", 64'({res_inf, res_zero, res_data}), 64'(exp_q[0]));

    op_valid   = v;
    op_a       = a;
    op_b       = b;
    res_ready  = rr;
    stray_done = sd;
    #1;
    acc      = v && op_ready;
    pop      = res_valid && rr && (exp_count > 0);
    cnt_done = mul_done && run && (exp_inflight > 0);
    if (mul_done && !run) flush_dones++;
    if (mul_done && run && exp_inflight == 0) exp_err = 1'b1;
    if (cnt_done && exp_count == DEPTH) exp_err = 1'b1;
    last_pop_val = {res_inf, res_zero, res_data};
    if (acc) exp_q.push_back(stub_mul(a, b));
    if (pop) void'(exp_q.pop_front());
    exp_inflight += int'(acc) - int'(cnt_done);
    exp_count    += int'(cnt_done && exp_count < DEPTH) - int'(pop);
    prev_acc = acc;
    if (acc) begin
      prev_a = a;
      prev_b = b;
    end
    if (flush_left > 0) flush_left--;
    last_acc = acc;
    last_pop = pop;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; op_valid = 1'b0; res_ready = 1'b0; stray_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_op_ready", 64'(op_ready), 64'(0));
    check("rst_mul_start", 64'(mul_start), 64'(0));
    check("rst_mul_in1", 64'(mul_in1), 64'(0));
    check("rst_mul_in2", 64'(mul_in2), 64'(0));
    check("rst_res_valid", 64'(res_valid), 64'(0));
    check("rst_inflight", 64'(inflight), 64'(0));
    check("rst_err", 64'(err), 64'(0));
    exp_q.delete();
    exp_inflight = 0; exp_count = 0; exp_err = 1'b0;
    prev_acc = 1'b0; prev_a = '0; prev_b = '0;
    flush_left = LAT; flush_dones = 0;
  endtask

  task automatic idle(input int n, input logic rr);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, rr, 1'b0);
  endtask

  initial begin
    vec_t vecs[5];
    int   lat, got, accepted, n;
    vecs[0] = '{a: P_ONE,         b: P_ONE,         data: P_ONE,         inf: 1'b0, zero: 1'b0};
    vecs[1] = '{a: 32'h0,         b: P_ONE,         data: 32'h0,         inf: 1'b0, zero: 1'b1};
    vecs[2] = '{a: P_NAR,         b: P_ONE,         data: P_NAR,         inf: 1'b1, zero: 1'b0};
    vecs[3] = '{a: P_ONE,         b: 32'h5A00_1234, data: 32'h5A00_1234, inf: 1'b0, zero: 1'b0};
    vecs[4] = '{a: 32'h3000_0000, b: P_NAR,         data: P_NAR,         inf: 1'b1, zero: 1'b0};

    reset_dut();
    idle(LAT, 1'b1);

    // Single ops with latency and result checks.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, vecs[i].a, vecs[i].b, 1'b1, 1'b0);
      check("vec_accept", 64'(last_acc), 64'(1));
      lat = 0; got = 0;
      while (!got && lat < 20) begin
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        lat++;
        if (last_pop) got = 1;
      end
      check("vec_latency", 64'(lat), 64'(LAT + 2));
      check("vec_result", 64'(last_pop_val), 64'({vecs[i].inf, vecs[i].zero, vecs[i].data}));
      $display("vector %0d: a=%h b=%h -> %h inf=%0b zero=%0b lat=%0d",
               i, vecs[i].a, vecs[i].b, last_pop_val[31:0], last_pop_val[33], last_pop_val[32], lat);
    end

    // Credit exhaustion with the result side stalled.
    accepted = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h4100_0000 + i, 32'h3F00_0000 + 3 * i, 1'b0, 1'b0);
      accepted += int'(last_acc);
    end
    check("bp_accepts", 64'(accepted), 64'(8));
    idle(LAT + 2, 1'b0);
    check("bp_inflight_zero", 64'(inflight), 64'(0));
    check("bp_res_valid", 64'(res_valid), 64'(1));
    idle(1, 1'b1);
    step(1'b1, 32'h4200_0000, 32'h4300_0000, 1'b0, 1'b0);
    check("bp_ninth", 64'(last_acc), 64'(1));
    idle(1, 1'b1);
    step(1'b1, 32'h4400_0000, 32'h4500_0000, 1'b1, 1'b0);
    check("accept_and_pop", 64'({last_acc, last_pop}), 64'(2'b11));
    for (int i = 0; i < 4; i++) step(1'b1, 32'h4600_0000 + i, 32'h4700_0000, 1'b1, 1'b0);
    idle(40, 1'b1);
    check("bp_drained", 64'(res_valid), 64'(0));
    $display("backpressure: accepted %0d of 10 while stalled", accepted);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom, $urandom, $urandom_range(0, 2) != 0, 1'b0);
    idle(40, 1'b1);
    $display("random phase complete: checks so far %0d", total);

    // Reset with three ops in flight: stale dones must land in FLUSH and be ignored.
    for (int i = 0; i < 3; i++) step(1'b1, P_ONE, 32'h4800_0000 + i, 1'b1, 1'b0);
    reset_dut();
    idle(LAT, 1'b1);
    check("flush_stale_dones", 64'(flush_dones), 64'(3));
    idle(1, 1'b1);
    check("post_flush_ready", 64'(op_ready), 64'(1));
    $display("mid-reset: %0d stale dones swallowed", flush_dones);

    // Zero then NaR, delivered in order.
    step(1'b1, 32'h0, P_ONE, 1'b0, 1'b0);
    step(1'b1, P_NAR, P_ONE, 1'b0, 1'b0);
    n = 0;
    for (int k = 0; k < 30; k++) begin
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      if (last_pop) begin
        if (n == 0) check("spec_zero", 64'(last_pop_val), 64'({2'b01, 32'h0}));
        else        check("spec_nar", 64'(last_pop_val), 64'({2'b10, P_NAR}));
        n++;
      end
    end
    check("spec_count", 64'(n), 64'(2));
    $display("special values: %0d results", n);

    // Stray done with nothing in flight.
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    idle(4, 1'b1);
    check("err_sticky", 64'(err), 64'(1));
    check("stray_no_res", 64'(res_valid), 64'(0));
    $display("stray done: err=%0b", err);
    reset_dut();
    idle(LAT + 1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
